// File: rtl/vm_pkg.sv
// Shared types and constants for the vending controller: FSM states,
// coin unit values and the per-slot price table.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } vm_state_e;

  localparam int unsigned COIN_HALF_UNITS = 1;
  localparam int unsigned COIN_ONE_UNITS  = 2;

  // PRICE[i] is the price of slot i in 0.5-yuan units
  localparam logic [3:0][7:0] PRICE = {8'd6, 8'd5, 8'd4, 8'd3};

  function automatic int unsigned coin_units(input logic [1:0] coin);
    case (coin)
      2'b01:   coin_units = COIN_HALF_UNITS;
      2'b10:   coin_units = COIN_ONE_UNITS;
      default: coin_units = 0;
    endcase
  endfunction

endpackage

// File: rtl/vm_stock.sv
// Per-slot stock counters: reload to INIT_STOCK, guarded single-slot
// decrement, and registered Empty flags that trail the counters by one cycle.
module vm_stock
  import vm_pkg::*;
#(
  parameter int NSLOT      = 4,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 8,
  localparam int SLOT_W    = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dec,
  input  logic [SLOT_W-1:0] i_dec_slot,
  input  logic              i_reload,
  output logic [NSLOT-1:0]  o_nz,
  output logic [NSLOT-1:0]  o_empty
);

  logic [STOCK_W-1:0] r_stock [NSLOT];
  logic [NSLOT-1:0]   r_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NSLOT; i++) begin
        r_stock[i] <= STOCK_W'(INIT_STOCK);
      end
      r_empty <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (i_reload) begin
          r_stock[i] <= STOCK_W'(INIT_STOCK);
        end else if (i_dec && (i_dec_slot == SLOT_W'(i)) && (r_stock[i] != '0)) begin
          r_stock[i] <= r_stock[i] - 1'b1;
        end
        r_empty[i] <= (r_stock[i] == '0);
      end
    end
  end

  always_comb begin
    o_nz = '0;
    for (int i = 0; i < NSLOT; i++) begin
      o_nz[i] = (r_stock[i] != '0);
    end
  end

  assign o_empty = r_empty;

endmodule

// File: rtl/cyq_vm_ctrl.sv
// Vending controller top: FSM, credit register, inactivity timeout and
// change-pulse toggle; stock bookkeeping lives in vm_stock.
module cyq_vm_ctrl
  import vm_pkg::*;
#(
  parameter int NSLOT      = 4,
  parameter int CREDIT_W   = 5,
  parameter int MAX_CREDIT = 10,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 8,
  parameter int TIMEOUT    = 1000,
  localparam int SLOT_W    = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_coin,
  input  logic [NSLOT-1:0]    i_sel,
  input  logic                i_cancel,
  input  logic                i_restock,
  input  logic                i_vend_ack,
  output logic                o_vend_req,
  output logic [SLOT_W-1:0]   o_vend_slot,
  output logic                o_chg_pulse,
  output logic                o_coin_rej,
  output logic                o_sel_err,
  output logic [CREDIT_W-1:0] o_credit,
  output logic [NSLOT-1:0]    o_empty
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  vm_state_e           r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
  logic [SLOT_W-1:0]   r_slot, w_slot_nxt;
  logic                r_chg, w_chg_nxt;
  logic                r_vend_req;
  logic                r_coin_rej, w_coin_rej_nxt;
  logic                r_sel_err, w_sel_err_nxt;

  logic                w_stock_dec;
  logic                w_reload;
  logic [NSLOT-1:0]    w_stock_nz;

  logic                w_coin_any;
  logic [1:0]          w_coin_units;
  logic [CREDIT_W:0]   w_credit_sum;
  logic                w_coin_fits;
  logic                w_sel_onehot;
  logic [SLOT_W-1:0]   w_sel_idx;
  logic [CREDIT_W-1:0] w_price;
  logic                w_sel_ok;

  vm_stock #(
    .NSLOT      (NSLOT),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_dec      (w_stock_dec),
    .i_dec_slot (r_slot),
    .i_reload   (w_reload),
    .o_nz       (w_stock_nz),
    .o_empty    (o_empty)
  );

  assign w_coin_any   = |i_coin;
  assign w_coin_units = 2'(coin_units(i_coin));
  assign w_credit_sum = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_units);
  assign w_coin_fits  = (w_coin_units != 2'd0) &&
                        (w_credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign w_sel_onehot = (i_sel != '0) && ((i_sel & (i_sel - 1'b1)) == '0);

  always_comb begin
    w_sel_idx = '0;
    w_price   = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (i_sel[i]) begin
        w_sel_idx = SLOT_W'(i);
        w_price   = CREDIT_W'(PRICE[i[1:0]]);
      end
    end
  end

  // Selection is judged against the credit registered before this cycle
  assign w_sel_ok = w_sel_onehot && (r_credit >= w_price) && w_stock_nz[w_sel_idx];

  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_tmo_nxt      = r_tmo;
    w_slot_nxt     = r_slot;
    w_chg_nxt      = 1'b0;
    w_coin_rej_nxt = 1'b0;
    w_sel_err_nxt  = 1'b0;
    w_stock_dec    = 1'b0;
    w_reload       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_credit_nxt = '0;
        w_tmo_nxt    = '0;
        w_reload     = i_restock;
        if (w_coin_any) begin
          if (w_coin_fits) begin
            w_credit_nxt = w_credit_sum[CREDIT_W-1:0];
            w_state_nxt  = ST_CREDIT;
          end else begin
            w_coin_rej_nxt = 1'b1;
          end
        end
      end
      ST_CREDIT: begin
        w_tmo_nxt = r_tmo + 1'b1;
        if (i_cancel) begin
          w_state_nxt    = ST_CHANGE;
          w_chg_nxt      = 1'b1;
          w_coin_rej_nxt = w_coin_any;
          w_tmo_nxt      = '0;
        end else if (w_sel_ok) begin
          w_state_nxt    = ST_VEND;
          w_credit_nxt   = r_credit - w_price;
          w_slot_nxt     = w_sel_idx;
          w_coin_rej_nxt = w_coin_any;
          w_tmo_nxt      = '0;
        end else begin
          w_sel_err_nxt = w_sel_onehot;
          if (w_coin_any) begin
            if (w_coin_fits) begin
              w_credit_nxt = w_credit_sum[CREDIT_W-1:0];
            end else begin
              w_coin_rej_nxt = 1'b1;
            end
          end
          // Any front-panel activity restarts the timer, even on the expiry cycle
          if (w_coin_any || (i_sel != '0)) begin
            w_tmo_nxt = '0;
          end else if (r_tmo >= TMO_W'(TIMEOUT - 1)) begin
            w_state_nxt = ST_CHANGE;
            w_chg_nxt   = 1'b1;
            w_tmo_nxt   = '0;
          end
        end
      end
      ST_VEND: begin
        w_coin_rej_nxt = w_coin_any;
        if (i_vend_ack) begin
          w_stock_dec = 1'b1;
          if (r_credit != '0) begin
            w_state_nxt = ST_CHANGE;
            w_chg_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_CHANGE: begin
        w_coin_rej_nxt = w_coin_any;
        if (r_chg) begin
          if (r_credit != '0) begin
            w_credit_nxt = r_credit - 1'b1;
          end
          if (r_credit <= CREDIT_W'(1)) begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_chg_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_credit   <= '0;
      r_tmo      <= '0;
      r_slot     <= '0;
      r_chg      <= 1'b0;
      r_vend_req <= 1'b0;
      r_coin_rej <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_tmo      <= w_tmo_nxt;
      r_slot     <= w_slot_nxt;
      r_chg      <= w_chg_nxt;
      r_vend_req <= (w_state_nxt == ST_VEND);
      r_coin_rej <= w_coin_rej_nxt;
      r_sel_err  <= w_sel_err_nxt;
    end
  end

  assign o_vend_req  = r_vend_req;
  assign o_vend_slot = r_slot;
  assign o_chg_pulse = r_chg;
  assign o_coin_rej  = r_coin_rej;
  assign o_sel_err   = r_sel_err;
  assign o_credit    = r_credit;

endmodule

// File: tb/tb_cyq_vm_ctrl.sv
// Scoreboard bench for cyq_vm_ctrl: directed stimulus pushes expected output
// events; a negedge monitor pops and compares each event the DUT presents.
module tb_cyq_vm_ctrl;

  localparam int EV_VEND   = 0;
  localparam int EV_VDROP  = 1;
  localparam int EV_SELERR = 2;
  localparam int EV_REJ    = 3;
  localparam int EV_CHG    = 4;
  localparam int EV_CRED   = 5;
  localparam int EV_EMPTY  = 6;
  localparam int TMO       = 1000;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin = '0;
  logic [3:0] sel = '0;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic       vend_ack = 1'b0;
  logic       vend_req;
  logic [1:0] vend_slot;
  logic       chg_pulse;
  logic       coin_rej;
  logic       sel_err;
  logic [4:0] credit;
  logic [3:0] empty;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  logic       prev_vreq = 1'b0;
  logic [4:0] prev_credit = '0;
  logic [3:0] prev_empty = '0;

  cyq_vm_ctrl #(.TIMEOUT(TMO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_coin      (coin),
    .i_sel       (sel),
    .i_cancel    (cancel),
    .i_restock   (restock),
    .i_vend_ack  (vend_ack),
    .o_vend_req  (vend_req),
    .o_vend_slot (vend_slot),
    .o_chg_pulse (chg_pulse),
    .o_coin_rej  (coin_rej),
    .o_sel_err   (sel_err),
    .o_credit    (credit),
    .o_empty     (empty)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      EV_VEND:   kname = "VEND";
      EV_VDROP:  kname = "VDROP";
      EV_SELERR: kname = "SELERR";
      EV_REJ:    kname = "REJ";
      EV_CHG:    kname = "CHG";
      EV_CRED:   kname = "CRED";
      default:   kname = "EMPTY";
    endcase
  endfunction

  task automatic push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // N units of change: pulse, then the decremented credit on the following cycle
  task automatic push_change(input int n);
    for (int k = n - 1; k >= 0; k--) begin
      push(EV_CHG, 0);
      push(EV_CRED, k);
    end
  endtask

  task automatic got(input int k, input int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: actual %s=%0d, required no event @%0t", kname(k), v, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL event_order: actual %s=%0d, required %s=%0d @%0t",
                 kname(k), v, kname(e.kind), e.val, $time);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [1:0] c, input logic [3:0] s, input logic cn, input logic ack);
    coin     = c;
    sel      = s;
    cancel   = cn;
    vend_ack = ack;
    @(posedge clk);
    #1;
    coin     = '0;
    sel      = '0;
    cancel   = 1'b0;
    vend_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (vend_req && !prev_vreq) got(EV_VEND, int'(vend_slot));
      if (!vend_req && prev_vreq) got(EV_VDROP, 0);
      if (sel_err)                got(EV_SELERR, 0);
      if (coin_rej)               got(EV_REJ, 0);
      if (chg_pulse)              got(EV_CHG, 0);
      if (credit != prev_credit)  got(EV_CRED, int'(credit));
      if (empty != prev_empty)    got(EV_EMPTY, int'(empty));
    end
    prev_vreq   = vend_req;
    prev_credit = credit;
    prev_empty  = empty;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vend_req", int'(vend_req), 0);
    chk("rst_chg_pulse", int'(chg_pulse), 0);
    chk("rst_coin_rej", int'(coin_rej), 0);
    chk("rst_sel_err", int'(sel_err), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_empty", int'(empty), 0);
    chk("rst_vend_slot", int'(vend_slot), 0);
    rst_n = 1'b1;
    idle(2);

    // Basic vend: 2+2 units, slot 1 at price 4, ack after two cycles
    push(EV_CRED, 2); step(2'b10, 4'b0000, 0, 0);
    push(EV_CRED, 4); step(2'b10, 4'b0000, 0, 0);
    push(EV_VEND, 1); push(EV_CRED, 0); step(2'b00, 4'b0010, 0, 0);
    idle(2);
    chk("vend_req_held", int'(vend_req), 1);
    push(EV_VDROP, 0); step(2'b00, 4'b0000, 0, 1);
    idle(4);

    // Vend with change: 6 units, slot 0 at price 3, ack on the first cycle
    push(EV_CRED, 2); step(2'b10, 4'b0000, 0, 0);
    push(EV_CRED, 4); step(2'b10, 4'b0000, 0, 0);
    push(EV_CRED, 6); step(2'b10, 4'b0000, 0, 0);
    push(EV_VEND, 0); push(EV_CRED, 3); step(2'b00, 4'b0001, 0, 0);
    push(EV_VDROP, 0); push_change(3); step(2'b00, 4'b0000, 0, 1);
    idle(8);

    // Refused selection on short credit, then cancel refunds 2 units
    push(EV_CRED, 2); step(2'b10, 4'b0000, 0, 0);
    push(EV_SELERR, 0); step(2'b00, 4'b1000, 0, 0);
    idle(2);
    chk("selerr_credit_kept", int'(credit), 2);
    push_change(2); step(2'b00, 4'b0000, 1, 0);
    idle(5);

    // Drain slot 2 (price 5) from 8 to 0
    for (int i = 0; i < 8; i++) begin
      push(EV_CRED, 2); step(2'b10, 4'b0000, 0, 0);
      push(EV_CRED, 4); step(2'b10, 4'b0000, 0, 0);
      push(EV_CRED, 5); step(2'b01, 4'b0000, 0, 0);
      push(EV_VEND, 2); push(EV_CRED, 0); step(2'b00, 4'b0100, 0, 0);
      idle(1);
      push(EV_VDROP, 0);
      if (i == 7) push(EV_EMPTY, 4);
      step(2'b00, 4'b0000, 0, 1);
      idle(2);
    end
    chk("empty_slot2", int'(empty), 4);
    push(EV_CRED, 2); step(2'b10, 4'b0000, 0, 0);
    push(EV_CRED, 4); step(2'b10, 4'b0000, 0, 0);
    push(EV_CRED, 5); step(2'b01, 4'b0000, 0, 0);
    push(EV_SELERR, 0); step(2'b00, 4'b0100, 0, 0);
    push_change(5); step(2'b00, 4'b0000, 1, 0);
    idle(12);

    // Ceiling, invalid coin, and cancel colliding with a coin
    for (int i = 1; i <= 5; i++) begin
      push(EV_CRED, 2 * i); step(2'b10, 4'b0000, 0, 0);
    end
    push(EV_REJ, 0); step(2'b01, 4'b0000, 0, 0);
    push(EV_REJ, 0); step(2'b11, 4'b0000, 0, 0);
    chk("ceiling_credit", int'(credit), 10);
    push(EV_REJ, 0); push_change(10); step(2'b01, 4'b0000, 1, 0);
    idle(24);

    // Sel colliding with a coin: coin returned, price taken from old credit
    push(EV_CRED, 2); step(2'b10, 4'b0000, 0, 0);
    push(EV_CRED, 4); step(2'b10, 4'b0000, 0, 0);
    push(EV_VEND, 0); push(EV_REJ, 0); push(EV_CRED, 1); step(2'b10, 4'b0001, 0, 0);
    idle(1);
    push(EV_VDROP, 0); push_change(1); step(2'b00, 4'b0000, 0, 1);
    idle(4);

    // Timeout refund after exactly TMO idle cycles
    push(EV_CRED, 1); step(2'b01, 4'b0000, 0, 0);
    push_change(1);
    idle(TMO - 1);
    chk("tmo_not_yet", int'(chg_pulse), 0);
    idle(1);
    chk("tmo_fired", int'(chg_pulse), 1);
    idle(4);

    // Coin on the expiry cycle is credited and no refund starts
    push(EV_CRED, 1); step(2'b01, 4'b0000, 0, 0);
    idle(TMO - 1);
    push(EV_CRED, 2); step(2'b01, 4'b0000, 0, 0);
    chk("expiry_coin_no_chg", int'(chg_pulse), 0);
    chk("expiry_coin_credit", int'(credit), 2);
    idle(3);
    push_change(2); step(2'b00, 4'b0000, 1, 0);
    idle(6);

    // Async reset during VEND, then slot 2 vends again from reloaded stock
    push(EV_CRED, 2); step(2'b10, 4'b0000, 0, 0);
    push(EV_CRED, 4); step(2'b10, 4'b0000, 0, 0);
    push(EV_CRED, 6); step(2'b10, 4'b0000, 0, 0);
    push(EV_VEND, 1); push(EV_CRED, 2); step(2'b00, 4'b0010, 0, 0);
    idle(1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vend_req", int'(vend_req), 0);
    chk("async_rst_credit", int'(credit), 0);
    chk("async_rst_empty", int'(empty), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(EV_CRED, 2); step(2'b10, 4'b0000, 0, 0);
    push(EV_CRED, 4); step(2'b10, 4'b0000, 0, 0);
    push(EV_CRED, 5); step(2'b01, 4'b0000, 0, 0);
    push(EV_VEND, 2); push(EV_CRED, 0); step(2'b00, 4'b0100, 0, 0);
    idle(1);
    push(EV_VDROP, 0); step(2'b00, 4'b0000, 0, 1);
    idle(4);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cyq_vm_ctrl.md
# cyq_vm_ctrl

Multi-slot vending controller that sequences the coin-credit datapath. Accumulates coin credit in 0.5-yuan units and validates selections against per-slot price and stock. Drives a req/ack handshake to the dispense mechanism, then pays change one 0.5-yuan coin per pulse. Sits between the front-panel inputs (coin slot, selection keys, cancel) and the dispense/change actuators.

## Interface
Parameters:
- NSLOT, 4, number of product slots.
- CREDIT_W, 5, credit register width, in 0.5-yuan units.
- MAX_CREDIT, 10, credit ceiling (5 yuan); must fit CREDIT_W.
- STOCK_W, 4, per-slot stock counter width.
- INIT_STOCK, 8, stock loaded at reset and on Restock.
- TIMEOUT, 1000, idle cycles in CREDIT before auto-refund.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset; one clock; reset is asynchronous and active-low.
- Coin  in  2  single-cycle coin pulse: [0]=0.5 yuan, [1]=1 yuan; 2'b11 is invalid and rejected.
- Sel  in  NSLOT  one-hot selection pulse; non-one-hot values are ignored.
- Cancel  in  1  refund request pulse.
- Restock  in  1  reloads all stock to INIT_STOCK; honoured in IDLE only.
- Vend_ack  in  1  dispense mechanism done.
- Vend_req  out  1  dispense request; held until ack.
- Vend_slot  out  log2(NSLOT)  slot being dispensed; valid while Vend_req.
- Chg_pulse  out  1  one 0.5-yuan change coin per high cycle.
- Coin_rej  out  1  one-cycle pulse: coin returned, not credited.
- Sel_err  out  1  one-cycle pulse: selection refused (credit short or slot empty).
- Credit  out  CREDIT_W  current credit.
- Empty  out  NSLOT  per-slot stock==0 flag.

## Operation
- **States:** IDLE, CREDIT, VEND, CHANGE.
- **Coin add:** an accepted coin adds 1 or 2 units. If the result would exceed MAX_CREDIT, the coin is rejected (Coin_rej) and credit is unchanged.
- **IDLE:** credit 0. Accepted coin → CREDIT. Restock → all stock = INIT_STOCK.
- **CREDIT:**
  - Coins accumulate.
  - Sel[i] with Credit ≥ PRICE[i] and stock[i] > 0 → VEND. Latch i; Credit -= PRICE[i] on that edge.
  - Any other Sel → Sel_err; stay in CREDIT.
  - Cancel → CHANGE.
  - Timeout counter clears on any coin, Sel or Cancel. When it reaches TIMEOUT → CHANGE.
- **VEND:**
  - Vend_req high.
  - Vend_ack sampled high → stock[slot]--, Vend_req low. Then → CHANGE if Credit > 0, else → IDLE.
  - Coins rejected; Sel and Cancel ignored.
- **CHANGE:**
  - Chg_pulse alternates high/low, starting high. Credit decrements at the edge ending each high cycle.
  - In a high cycle with Credit == 1 → IDLE.
  - Coins rejected; Sel and Cancel ignored.
- **Same-cycle priority in CREDIT:** Cancel > Sel > Coin.
  - A coin in the same cycle as an accepted Cancel or Sel is rejected.
  - Sel is checked against the credit registered before that cycle.
  - A coin in the same cycle as timeout expiry wins: it is credited and the timer clears.
- **Arithmetic:** all arithmetic is unsigned. Credit never underflows (guarded by the price check). Stock never decrements below 0.

## Timing
- **Reset values:** all outputs 0, Credit 0, Empty all 0, state IDLE, stock INIT_STOCK.
- **Reset mid-operation:** Vend_req and Chg_pulse drop asynchronously; credit is lost.
- **Registered outputs:** every output is registered. A response appears the cycle after the input is sampled:
  - Credit update 1 cycle after the coin.
  - Vend_req 1 cycle after Sel.
  - Coin_rej and Sel_err are 1-cycle pulses, 1 cycle after the cause.
- **Vend_ack:** may arrive in the first Vend_req cycle or later. No timeout on ack. Vend_req falls the cycle after ack.
- **Change duration:** N units of change take 2N−1 cycles of CHANGE; IDLE follows.
- **Empty:** updates the cycle after the stock decrement.

## Structure
- **Package vm_pkg:**
  - State enum.
  - Coin unit values.
  - PRICE[NSLOT] constants, default 3,4,5,6 units.
- **Sub-module vm_stock:** per-slot stock counters with decrement(slot), reload, and Empty flags.
- **Top level:** FSM, credit register, timeout counter, change toggle.

## Test plan
- **Basic vend:** Coin[1] ×2, then Sel[1] (price 4) → Credit 2, 4, then 0. Vend_req with Vend_slot=1 until ack. No Chg_pulse. Stock[1]=7.
- **Vend with change:** Credit 6, Sel[0] (price 3) → vend, then 3 Chg_pulse in cycles 0,2,4 of CHANGE, then IDLE.
- **Refused selection:** Credit 2, Sel[3] → Sel_err pulse, still CREDIT, Credit 2. Drain slot 2 to 0 → Empty[2]=1; later Sel[2] → Sel_err.
- **Ceiling and collisions:** Credit 10, Coin[0] → Coin_rej, Credit 10. Cancel and Coin in the same cycle → Coin_rej, then 10 change pulses.
- **Timeout:** Credit 1, no activity for TIMEOUT cycles → CHANGE, 1 pulse, then IDLE. A coin on the expiry cycle → credited, no refund.
- **Async reset:** Rst low during VEND → Vend_req 0 immediately, Credit 0, stock back to INIT_STOCK after release.
